// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: command/data stream to SINGLE/INCR4/INCR8/INCR16 transfers; optional cmd_prot via AHB_MST_PROT_EN.
// Latency: first address phase one cycle after command capture; done one cycle after the final data phase.
// Backpressure: cmd_ready only in IDLE; missing write data inserts BUSY (IDLE before the first beat); HREADY=0 freezes the bus.
module ahb_lite_master #(
  parameter int         ADDR_WIDTH    = 32,
  parameter int         DATA_WIDTH    = 32,
  parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_len,
`ifdef AHB_MST_PROT_EN
  input  logic [3:0]            cmd_prot,
`endif
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ERR} state_t;
  state_t state_q, state_nxt;

  logic                  cmd_write_q, first_q, dp_vld, dp_write;
  logic [2:0]            cmd_size_q, burst_enc;
  logic [1:0]            cmd_len_q;
  logic [4:0]            issue_left, beats;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] stg_dat;
  logic [10:0]           span;
  logic                  misalign, bad_cmd;
  logic                  accept, adv, issue, busy_slot, rd_done, fin, fin_err, err_first;

  // Command legality: size, alignment, and the whole burst staying inside one 1KB page.
  always_comb begin
    case (cmd_len)
      2'b00:   beats = 5'd1;
      2'b01:   beats = 5'd4;
      2'b10:   beats = 5'd8;
      default: beats = 5'd16;
    endcase
    span = 11'(beats) << cmd_size;
    case (cmd_size)
      3'd1:    misalign = cmd_addr[0];
      3'd2:    misalign = |cmd_addr[1:0];
      default: misalign = 1'b0;
    endcase
    bad_cmd = (cmd_size > 3'd2) || misalign || (({1'b0, cmd_addr[9:0]} + span) > 11'd1024);
  end

  always_comb begin
    case (cmd_len_q)
      2'b00:   burst_enc = 3'b000;
      2'b01:   burst_enc = 3'b011;
      2'b10:   burst_enc = 3'b101;
      default: burst_enc = 3'b111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    accept      = 1'b0;
    adv         = 1'b0;
    issue       = 1'b0;
    busy_slot   = 1'b0;
    rd_done     = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    err_first   = 1'b0;
    wdata_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          if (bad_cmd) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (dp_vld && HRESP) begin
          // A single-cycle error response still terminates the command.
          if (HREADY) begin
            fin       = 1'b1;
            fin_err   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err_first = 1'b1;
            state_nxt = S_ERR;
          end
        end else if (HREADY) begin
          adv     = 1'b1;
          rd_done = dp_vld && !dp_write;
          if (issue_left != 5'd0) begin
            if (cmd_write_q && !wdata_valid) begin
              busy_slot = 1'b1;
            end else begin
              issue       = 1'b1;
              wdata_ready = cmd_write_q;
            end
          end else if (HTRANS[1]) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (HREADY) begin
          fin       = 1'b1;
          fin_err   = HRESP;
          rd_done   = !dp_write && !HRESP;
          state_nxt = S_IDLE;
        end else if (HRESP) begin
          err_first = 1'b1;
          state_nxt = S_ERR;
        end
      end
      default: begin
        if (HREADY) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      cmd_ready   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'd0;
      HBURST      <= 3'd0;
      HTRANS      <= HT_IDLE;
      HWDATA      <= '0;
      cmd_write_q <= 1'b0;
      cmd_size_q  <= 3'd0;
      cmd_len_q   <= 2'd0;
      nxt_addr    <= '0;
      issue_left  <= 5'd0;
      first_q     <= 1'b0;
      dp_vld      <= 1'b0;
      dp_write    <= 1'b0;
      stg_dat     <= '0;
    end else begin
      cmd_ready   <= (state_nxt == S_IDLE);
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (accept) begin
        cmd_write_q <= cmd_write;
        cmd_size_q  <= cmd_size;
        cmd_len_q   <= cmd_len;
        nxt_addr    <= cmd_addr;
        issue_left  <= beats;
        first_q     <= 1'b1;
      end
      if (adv) begin
        // The beat on the bus (if any) is accepted here and moves into its data phase.
        dp_vld   <= HTRANS[1];
        dp_write <= HWRITE;
        if (HTRANS[1] && HWRITE) HWDATA <= stg_dat;
        if (issue) begin
          HTRANS     <= first_q ? HT_NONSEQ : HT_SEQ;
          HADDR      <= nxt_addr;
          HWRITE     <= cmd_write_q;
          HSIZE      <= cmd_size_q;
          HBURST     <= burst_enc;
          nxt_addr   <= nxt_addr + (ADDR_WIDTH'(1) << cmd_size_q);
          issue_left <= issue_left - 5'd1;
          first_q    <= 1'b0;
          if (cmd_write_q) stg_dat <= wdata;
        end else if (busy_slot) begin
          HTRANS <= first_q ? HT_IDLE : HT_BUSY;
          HADDR  <= nxt_addr;
        end else begin
          HTRANS <= HT_IDLE;
        end
      end
      if (rd_done) begin
        rdata       <= HRDATA;
        rdata_valid <= 1'b1;
      end
      if (err_first) begin
        HTRANS <= HT_IDLE;
        dp_vld <= 1'b0;
      end
      if (fin) begin
        done   <= 1'b1;
        err    <= fin_err;
        HTRANS <= HT_IDLE;
        dp_vld <= 1'b0;
      end
    end
  end

`ifdef AHB_MST_PROT_EN
  logic [3:0] hprot_q;
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET)     hprot_q <= HPROT_DEFAULT;
    else if (accept) hprot_q <= cmd_prot;
  end
  assign HPROT = hprot_q;
`else
  assign HPROT = HPROT_DEFAULT;
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small zero-wait slave whose read data encodes the data-phase address.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_len = '0;
`ifdef AHB_MST_PROT_EN
  logic [3:0]  cmd_prot = 4'b0011;
`endif
  logic [31:0] wdata = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_len(cmd_len),
`ifdef AHB_MST_PROT_EN
    .cmd_prot(cmd_prot),
`endif
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // Slave data phase tracking: address captured at negedge, data phase starts at the following posedge.
  logic [31:0] dp_addr = '0, nx_addr = '0;
  logic        nx_vld = 1'b0;
  assign HRDATA = {16'hA5A5, dp_addr[15:0]};
  always @(posedge HCLK) if (nx_vld) dp_addr <= nx_addr;

  logic [31:0] acc_addr[$];
  logic [1:0]  acc_trans[$];
  logic [31:0] rd_q[$];
  int          done_cnt = 0;
  logic        last_err = 1'b0;

  always @(negedge HCLK) begin
    nx_vld  = HRESET && HREADY && HTRANS[1];
    nx_addr = HADDR;
    if (nx_vld) begin
      acc_addr.push_back(HADDR);
      acc_trans.push_back(HTRANS);
    end
    if (rdata_valid) rd_q.push_back(rdata);
    if (done) begin
      done_cnt++;
      last_err = err;
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_rec;
    acc_addr.delete();
    acc_trans.delete();
    rd_q.delete();
    done_cnt = 0;
    last_err = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] l);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick;
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = s;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    #2 HRESET = 1'b0;
    tick;
    tick;
    total++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd0 || HBURST !== 3'd0 || HWDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus: trans=%h addr=%h wr=%b size=%h burst=%h wdata=%h want all 0", HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA);
    end
    total++;
    if (HPROT !== 4'b0011) begin
      bad++;
      $display("FAIL reset_hprot: got %h want 3", HPROT);
    end
    total++;
    if ({cmd_ready, rdata_valid, done, err} !== 4'b0000 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_ctrl: rdy/rv/done/err=%b rdata=%h want 0000/0", {cmd_ready, rdata_valid, done, err}, rdata);
    end
    HRESET = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want 0", cmd_ready);
    end
    tick;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single_write;
    clear_rec;
    wdata       = 32'hDEADBEEF;
    wdata_valid = 1'b1;
    send_cmd(32'h10, 1'b1, 3'd2, 2'b00);
    #1;
    total++;
    if (wdata_ready !== 1'b1) begin
      bad++;
      $display("FAIL sw_wdata_ready: got %b want 1", wdata_ready);
    end
    tick;
    wdata_valid = 1'b0;
    total++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HBURST !== 3'b000 || HWRITE !== 1'b1 || HSIZE !== 3'd2 || HPROT !== 4'b0011) begin
      bad++;
      $display("FAIL sw_addr_phase: trans=%h addr=%h burst=%h wr=%b size=%h prot=%h want 2/10/0/1/2/3", HTRANS, HADDR, HBURST, HWRITE, HSIZE, HPROT);
    end
    tick;
    total++;
    if (HTRANS !== 2'b00 || HWDATA !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL sw_data_phase: trans=%h hwdata=%h want 0/deadbeef", HTRANS, HWDATA);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL sw_done_early: got %b want 0", done);
    end
    tick;
    total++;
    if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL sw_done: done=%b err=%b rdy=%b want 1/0/1", done, err, cmd_ready);
    end
    tick;
  endtask

  task automatic test_incr4_read_wait;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108; exp_a[3] = 32'h10C;
    clear_rec;
    send_cmd(32'h100, 1'b0, 3'd2, 2'b01);
    for (int c = 0; c < 11; c++) begin
      HREADY = !(c == 3 || c == 4);
      #1;
      if (c == 1) begin
        total++;
        if (HTRANS !== 2'b10 || HBURST !== 3'b011) begin
          bad++;
          $display("FAIL r4_first: trans=%h burst=%h want 2/3", HTRANS, HBURST);
        end
      end
      if (c == 4 || c == 5) begin
        total++;
        if (HADDR !== 32'h108 || HTRANS !== 2'b11) begin
          bad++;
          $display("FAIL r4_hold_c%0d: addr=%h trans=%h want 108/3", c, HADDR, HTRANS);
        end
      end
      tick;
    end
    HREADY = 1'b1;
    total++;
    if (acc_addr.size() != 4) begin
      bad++;
      $display("FAIL r4_beats: got %0d want 4", acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_addr[i] !== exp_a[i] || acc_trans[i] !== ((i == 0) ? 2'b10 : 2'b11)) begin
          bad++;
          $display("FAIL r4_beat%0d: addr=%h trans=%h want %h/%0d", i, acc_addr[i], acc_trans[i], exp_a[i], (i == 0) ? 2 : 3);
        end
      end
    end
    total++;
    if (rd_q.size() != 4) begin
      bad++;
      $display("FAIL r4_rcount: got %0d want 4", rd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rd_q[i] !== {16'hA5A5, exp_a[i][15:0]}) begin
          bad++;
          $display("FAIL r4_rdata%0d: got %h want %h", i, rd_q[i], {16'hA5A5, exp_a[i][15:0]});
        end
      end
    end
    total++;
    if (done_cnt != 1 || last_err !== 1'b0) begin
      bad++;
      $display("FAIL r4_done: count=%0d err=%b want 1/0", done_cnt, last_err);
    end
  endtask

  task automatic test_incr4_write_busy;
    logic [31:0] d [4];
    logic [31:0] hw_q[$];
    logic [31:0] last_hw;
    int k, busy_n, busy_wrong;
    logic hs;
    d[0] = 32'hA0A00001; d[1] = 32'hB0B00002; d[2] = 32'hC0C00003; d[3] = 32'hD0D00004;
    k = 0; busy_n = 0; busy_wrong = 0;
    clear_rec;
    last_hw     = HWDATA;
    wdata       = d[0];
    wdata_valid = 1'b1;
    send_cmd(32'h200, 1'b1, 3'd2, 2'b01);
    for (int c = 0; c < 13; c++) begin
      wdata       = (k < 4) ? d[k] : 32'h0;
      wdata_valid = (k < 4) && !(c >= 2 && c <= 4);
      #1;
      hs = wdata_ready && wdata_valid;
      tick;
      if (hs) k++;
      if (HTRANS === 2'b01) begin
        busy_n++;
        if (HADDR !== 32'h208) busy_wrong++;
      end
      if (HWDATA !== last_hw) begin
        hw_q.push_back(HWDATA);
        last_hw = HWDATA;
      end
    end
    wdata_valid = 1'b0;
    total++;
    if (k != 4) begin
      bad++;
      $display("FAIL w4_handshakes: got %0d want 4", k);
    end
    total++;
    if (busy_n != 3 || busy_wrong != 0) begin
      bad++;
      $display("FAIL w4_busy: cycles=%0d wrong_addr=%0d want 3/0", busy_n, busy_wrong);
    end
    total++;
    if (acc_addr.size() != 4) begin
      bad++;
      $display("FAIL w4_beats: got %0d want 4", acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_addr[i] !== 32'h200 + 32'(4 * i) || acc_trans[i] !== ((i == 0) ? 2'b10 : 2'b11)) begin
          bad++;
          $display("FAIL w4_beat%0d: addr=%h trans=%h want %h", i, acc_addr[i], acc_trans[i], 32'h200 + 32'(4 * i));
        end
      end
    end
    total++;
    if (hw_q.size() != 4) begin
      bad++;
      $display("FAIL w4_hwcount: got %0d want 4", hw_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (hw_q[i] !== d[i]) begin
          bad++;
          $display("FAIL w4_hwdata%0d: got %h want %h", i, hw_q[i], d[i]);
        end
      end
    end
    total++;
    if (done_cnt != 1 || last_err !== 1'b0) begin
      bad++;
      $display("FAIL w4_done: count=%0d err=%b want 1/0", done_cnt, last_err);
    end
  endtask

  task automatic test_incr8_error;
    int seq_after;
    seq_after = 0;
    clear_rec;
    send_cmd(32'h300, 1'b0, 3'd2, 2'b10);
    for (int c = 0; c < 11; c++) begin
      HREADY = (c != 4);
      HRESP  = (c == 4 || c == 5);
      #1;
      if (c == 1) begin
        total++;
        if (HBURST !== 3'b101) begin
          bad++;
          $display("FAIL e8_burst: got %h want 5", HBURST);
        end
      end
      if (c == 5) begin
        total++;
        if (HTRANS !== 2'b00) begin
          bad++;
          $display("FAIL e8_idle_2nd: got %h want 0", HTRANS);
        end
      end
      if (c >= 5 && HTRANS[1]) seq_after++;
      tick;
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    total++;
    if (seq_after != 0 || acc_addr.size() != 3) begin
      bad++;
      $display("FAIL e8_abandon: late_beats=%0d accepted=%0d want 0/3", seq_after, acc_addr.size());
    end
    total++;
    if (rd_q.size() != 2) begin
      bad++;
      $display("FAIL e8_rcount: got %0d want 2", rd_q.size());
    end else begin
      total++;
      if (rd_q[0] !== 32'hA5A50300 || rd_q[1] !== 32'hA5A50304) begin
        bad++;
        $display("FAIL e8_rdata: got %h %h want a5a50300 a5a50304", rd_q[0], rd_q[1]);
      end
    end
    total++;
    if (done_cnt != 1 || last_err !== 1'b1) begin
      bad++;
      $display("FAIL e8_done: count=%0d err=%b want 1/1", done_cnt, last_err);
    end
  endtask

  task automatic test_reject;
    logic [31:0] va [3];
    logic [2:0]  vs [3];
    logic [1:0]  vl [3];
    logic        vw [3];
    int act;
    va[0] = 32'h3F8; vs[0] = 3'd2; vl[0] = 2'b11; vw[0] = 1'b0;
    va[1] = 32'h102; vs[1] = 3'd2; vl[1] = 2'b00; vw[1] = 1'b1;
    va[2] = 32'h040; vs[2] = 3'd3; vl[2] = 2'b00; vw[2] = 1'b0;
    for (int v = 0; v < 3; v++) begin
      clear_rec;
      act         = 0;
      wdata       = 32'h5555AAAA;
      wdata_valid = vw[v];
      send_cmd(va[v], vw[v], vs[v], vl[v]);
      total++;
      if (done !== 1'b1 || err !== 1'b1) begin
        bad++;
        $display("FAIL rej%0d_flag: done=%b err=%b want 1/1", v, done, err);
      end
      for (int c = 0; c < 4; c++) begin
        #1;
        if (HTRANS !== 2'b00 || wdata_ready) act++;
        tick;
      end
      wdata_valid = 1'b0;
      total++;
      if (act != 0) begin
        bad++;
        $display("FAIL rej%0d_bus: active_cycles=%0d want 0", v, act);
      end
      total++;
      if (done_cnt != 1) begin
        bad++;
        $display("FAIL rej%0d_count: got %0d want 1", v, done_cnt);
      end
    end
  endtask

  task automatic test_boundary_ok;
    clear_rec;
    send_cmd(32'h3C0, 1'b0, 3'd2, 2'b11);
    for (int c = 0; c < 25; c++) tick;
    total++;
    if (done_cnt != 1 || last_err !== 1'b0) begin
      bad++;
      $display("FAIL b16_done: count=%0d err=%b want 1/0", done_cnt, last_err);
    end
    total++;
    if (rd_q.size() != 16 || acc_addr.size() != 16) begin
      bad++;
      $display("FAIL b16_count: reads=%0d beats=%0d want 16/16", rd_q.size(), acc_addr.size());
    end else begin
      total++;
      if (acc_addr[15] !== 32'h3FC || rd_q[15] !== 32'hA5A503FC) begin
        bad++;
        $display("FAIL b16_last: addr=%h rdata=%h want 3fc/a5a503fc", acc_addr[15], rd_q[15]);
      end
    end
  endtask

  task automatic test_reset_mid;
    clear_rec;
    send_cmd(32'h400, 1'b0, 3'd2, 2'b10);
    tick;
    tick;
    tick;
    total++;
    if (rdata_valid !== 1'b1 || HTRANS !== 2'b11) begin
      bad++;
      $display("FAIL rm_pre: rv=%b trans=%h want 1/3", rdata_valid, HTRANS);
    end
    #2 HRESET = 1'b0;
    #1;
    total++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HBURST !== 3'd0 || HSIZE !== 3'd0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      bad++;
      $display("FAIL rm_bus: trans=%h addr=%h burst=%h size=%h wr=%b wdata=%h want all 0", HTRANS, HADDR, HBURST, HSIZE, HWRITE, HWDATA);
    end
    total++;
    if ({cmd_ready, rdata_valid, done, err} !== 4'b0000 || rdata !== 32'h0 || HPROT !== 4'b0011) begin
      bad++;
      $display("FAIL rm_ctrl: rdy/rv/done/err=%b rdata=%h prot=%h want 0000/0/3", {cmd_ready, rdata_valid, done, err}, rdata, HPROT);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    tick;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_ready: got %b want 1", cmd_ready);
    end
    clear_rec;
    wdata       = 32'hCAFEF00D;
    wdata_valid = 1'b1;
    send_cmd(32'h20, 1'b1, 3'd2, 2'b00);
    tick;
    wdata_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    total++;
    if (acc_addr.size() != 1 || HWDATA !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL rm_single: beats=%0d hwdata=%h want 1/cafef00d", acc_addr.size(), HWDATA);
    end else begin
      total++;
      if (acc_addr[0] !== 32'h20 || acc_trans[0] !== 2'b10) begin
        bad++;
        $display("FAIL rm_single_addr: addr=%h trans=%h want 20/2", acc_addr[0], acc_trans[0]);
      end
    end
    total++;
    if (done_cnt != 1 || last_err !== 1'b0) begin
      bad++;
      $display("FAIL rm_done: count=%0d err=%b want 1/0", done_cnt, last_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_write;
    test_incr4_read_wait;
    test_incr4_write_busy;
    test_incr8_error;
    test_reject;
    test_boundary_ok;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
